lpm_and_serial: RTL and testbench

- Sequential front-end to the parameterized AND gate. It accepts the lpm_size input buses one per beat over a valid/ready stream, and ANDs them bit-wise into an accumulator.
- It emits one lpm_width result per frame on a valid/ready output.
- Used in the GPU wherever operand buses arrive serially, e.g. per-lane predicate masks from successive cores, instead of as one wide lpm_size*lpm_width vector.

---
 rtl/lpm_and_serial.sv | 110 +++++++++++
 tb/tb_lpm_and_serial.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lpm_and_serial.sv
// Serial bit-wise AND: folds up to lpm_size input beats into one lpm_width
// result per frame, with valid/ready handshakes on both sides.
module lpm_and_serial #(
    parameter int lpm_width  = 1,
    parameter int lpm_size   = 2,
    parameter int lpm_widthc = 8,
    parameter     lpm_type   = "lpm_and_serial"
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  sclr,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [lpm_width-1:0]  in_data,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [lpm_width-1:0]  out_result,
    output logic [lpm_widthc-1:0] out_beats
);

    if (lpm_width <= 0 || lpm_size <= 0 || lpm_size >= (2 ** lpm_widthc)) begin : g_param_err
        $fatal(1, "lpm_and_serial: illegal lpm_width/lpm_size/lpm_widthc");
    end

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_e;

    localparam logic [lpm_widthc-1:0] CNT_LAST = lpm_widthc'(lpm_size - 1);

    state_e                  state_q, state_d;
    logic [lpm_widthc-1:0]   cnt_q, cnt_d;
    logic [lpm_widthc-1:0]   beats_q, beats_d;
    logic [lpm_width-1:0]    acc_q, acc_d;
    logic [lpm_width-1:0]    res_q, res_d;
    logic [lpm_width-1:0]    acc_next;
    logic                    accept, xfer, close;

    assign accept   = in_valid & in_ready;
    assign xfer     = out_valid & out_ready;
    assign acc_next = (cnt_q == '0) ? in_data : (acc_q & in_data);
    // in_last on the beat that also hits the size limit is still just one close.
    assign close    = accept & (in_last | (cnt_q == CNT_LAST));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its peers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ACCUM;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (sclr) begin
            state_d = ACCUM;
        end else if (close) begin
            state_d = HOLD;
        end else if (xfer) begin
            state_d = ACCUM;
        end
    end

    always_comb begin
        out_valid = (state_q == HOLD);
        in_ready  = !out_valid | out_ready;
    end

    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        res_d   = res_q;
        beats_d = beats_q;
        if (sclr) begin
            cnt_d = '0;
            acc_d = '0;
        end else if (close) begin
            acc_d   = acc_next;
            res_d   = acc_next;
            beats_d = cnt_q + lpm_widthc'(1);
            cnt_d   = '0;
        end else if (accept) begin
            acc_d = acc_next;
            cnt_d = cnt_q + lpm_widthc'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q   <= '0;
            acc_q   <= '0;
            res_q   <= '0;
            beats_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
            beats_q <= beats_d;
        end
    end

    assign out_result = res_q;
    assign out_beats  = beats_q;

endmodule

// File: tb/tb_lpm_and_serial.sv
// Bench for lpm_and_serial: a lpm_size=3 and a lpm_size=1 instance checked
// against a behavioural frame model whose closed frames queue up as expected results.
module tb_lpm_and_serial;

    localparam int W  = 4;
    localparam int WC = 8;

    typedef struct {
        logic [W-1:0] res;
        int           beats;
    } exp_t;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    logic          a_sclr = 0, a_in_valid = 0, a_in_last = 0, a_out_ready = 1;
    logic [W-1:0]  a_in_data = '0;
    logic          a_in_ready, a_out_valid;
    logic [W-1:0]  a_out_result;
    logic [WC-1:0] a_out_beats;

    logic          b_sclr = 0, b_in_valid = 0, b_in_last = 0, b_out_ready = 1;
    logic [W-1:0]  b_in_data = '0;
    logic          b_in_ready, b_out_valid;
    logic [W-1:0]  b_out_result;
    logic [WC-1:0] b_out_beats;

    lpm_and_serial #(.lpm_width(W), .lpm_size(3), .lpm_widthc(WC)) dut_a (
        .clock(clock), .reset_n(reset_n), .sclr(a_sclr),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_last(a_in_last),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_result(a_out_result), .out_beats(a_out_beats)
    );

    lpm_and_serial #(.lpm_width(W), .lpm_size(1), .lpm_widthc(WC)) dut_b (
        .clock(clock), .reset_n(reset_n), .sclr(b_sclr),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_last(b_in_last),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_result(b_out_result), .out_beats(b_out_beats)
    );

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model, one slot per instance.
    exp_t         sbq[2][$];
    int           mcnt[2];
    logic [W-1:0] macc[2];
    int           msize[2] = '{3, 1};

    function automatic void model_clear();
        for (int k = 0; k < 2; k++) begin
            sbq[k].delete();
            mcnt[k] = 0;
            macc[k] = '0;
        end
    endfunction

    task automatic model_step(input int k, input logic iv, input logic [W-1:0] din,
                              input logic il, input logic ordy, input logic sc,
                              input logic ov, input logic irdy,
                              input logic [W-1:0] res, input logic [WC-1:0] beats);
        logic         exp_rdy;
        logic [W-1:0] a;
        exp_t         e;
        exp_rdy = (sbq[k].size() == 0) || ordy;
        check($sformatf("in_ready%0d", k), irdy, exp_rdy);
        check($sformatf("out_valid%0d", k), ov, sbq[k].size() != 0);
        if (sbq[k].size() != 0) begin
            check($sformatf("out_result%0d", k), res, sbq[k][0].res);
            check($sformatf("out_beats%0d", k), beats, sbq[k][0].beats);
        end
        if (sc) begin
            sbq[k].delete();
            mcnt[k] = 0;
            macc[k] = '0;
        end else begin
            if (sbq[k].size() != 0 && ordy) void'(sbq[k].pop_front());
            if (iv && exp_rdy) begin
                a = (mcnt[k] == 0) ? din : (macc[k] & din);
                macc[k] = a;
                if (il || mcnt[k] == msize[k] - 1) begin
                    e.res   = a;
                    e.beats = mcnt[k] + 1;
                    sbq[k].push_back(e);
                    mcnt[k] = 0;
                end else begin
                    mcnt[k]++;
                end
            end
        end
    endtask

    // Monitor samples 1 time unit before each rising edge.
    always begin
        @(negedge clock);
        #4;
        if (reset_n) begin
            model_step(0, a_in_valid, a_in_data, a_in_last, a_out_ready, a_sclr,
                       a_out_valid, a_in_ready, a_out_result, a_out_beats);
            model_step(1, b_in_valid, b_in_data, b_in_last, b_out_ready, b_sclr,
                       b_out_valid, b_in_ready, b_out_result, b_out_beats);
        end
    end

    task automatic drive(input int k, input logic v, input logic [W-1:0] d,
                         input logic l, input logic ordy, input logic sc);
        @(negedge clock);
        a_in_valid  = (k == 0) ? v    : 1'b0;
        a_in_data   = (k == 0) ? d    : '0;
        a_in_last   = (k == 0) ? l    : 1'b0;
        a_out_ready = (k == 0) ? ordy : 1'b1;
        a_sclr      = (k == 0) ? sc   : 1'b0;
        b_in_valid  = (k == 1) ? v    : 1'b0;
        b_in_data   = (k == 1) ? d    : '0;
        b_in_last   = (k == 1) ? l    : 1'b0;
        b_out_ready = (k == 1) ? ordy : 1'b1;
        b_sclr      = (k == 1) ? sc   : 1'b0;
    endtask

    task automatic idle();
        drive(0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        model_clear();
        repeat (3) @(negedge clock);
        #1;
        check("rst_out_valid", a_out_valid, 0);
        check("rst_in_ready", a_in_ready, 1);
        check("rst_out_result", a_out_result, 0);
        check("rst_out_beats", a_out_beats, 0);
        reset_n = 1'b1;

        // Full-length frame.
        drive(0, 1, 4'hF, 0, 1, 0);
        drive(0, 1, 4'hB, 0, 1, 0);
        drive(0, 1, 4'h6, 0, 1, 0);
        idle(); #1;
        check("full_valid", a_out_valid, 1);
        check("full_result", a_out_result, 4'h2);
        check("full_beats", a_out_beats, 3);

        // Early close, then a fresh frame overlapping the transfer.
        drive(0, 1, 4'hE, 0, 1, 0);
        drive(0, 1, 4'h7, 1, 1, 0);
        drive(0, 1, 4'h1, 0, 1, 0); #1;
        check("early_result", a_out_result, 4'h6);
        check("early_beats", a_out_beats, 2);
        drive(0, 1, 4'h3, 1, 1, 0);
        idle(); #1;
        check("fresh_result", a_out_result, 4'h1);
        check("fresh_beats", a_out_beats, 2);
        idle();

        // Backpressure for 5 cycles, release together with a new beat.
        drive(0, 1, 4'h5, 0, 0, 0);
        drive(0, 1, 4'h5, 0, 0, 0);
        drive(0, 1, 4'h5, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            drive(0, 1, 4'hA, 0, 0, 0); #1;
            check("bp_in_ready", a_in_ready, 0);
            check("bp_result", a_out_result, 4'h5);
        end
        drive(0, 1, 4'hA, 0, 1, 0);
        drive(0, 1, 4'hC, 0, 1, 0);
        drive(0, 1, 4'hF, 0, 1, 0);
        idle(); #1;
        check("bp_next_result", a_out_result, 4'h8);
        check("bp_next_beats", a_out_beats, 3);
        idle();

        // sclr in HOLD under backpressure, then sclr discarding an accepted beat.
        drive(0, 1, 4'h3, 0, 0, 0);
        drive(0, 1, 4'h3, 1, 0, 0);
        drive(0, 1, 4'hF, 0, 0, 1);
        idle(); #1;
        check("sclr_out_valid", a_out_valid, 0);
        drive(0, 1, 4'h0, 0, 1, 0);
        drive(0, 1, 4'h0, 0, 1, 1);
        drive(0, 1, 4'h9, 0, 1, 0);
        drive(0, 1, 4'hD, 0, 1, 0);
        drive(0, 1, 4'hF, 0, 1, 0);
        idle(); #1;
        check("sclr_next_result", a_out_result, 4'h9);
        check("sclr_next_beats", a_out_beats, 3);
        idle();

        // Asynchronous reset mid-frame.
        drive(0, 1, 4'h0, 0, 1, 0);
        drive(0, 1, 4'h0, 0, 1, 0);
        idle();
        #1 reset_n = 1'b0;
        #1;
        check("arst_out_valid", a_out_valid, 0);
        check("arst_in_ready", a_in_ready, 1);
        check("arst_out_result", a_out_result, 0);
        check("arst_out_beats", a_out_beats, 0);
        reset_n = 1'b1;
        model_clear();
        drive(0, 1, 4'hF, 0, 1, 0);
        drive(0, 1, 4'hF, 0, 1, 0);
        drive(0, 1, 4'hF, 0, 1, 0);
        idle(); #1;
        check("arst_next_result", a_out_result, 4'hF);
        check("arst_next_beats", a_out_beats, 3);
        idle();

        // lpm_size=1 back-to-back stream.
        drive(1, 1, 4'h3, 0, 1, 0);
        drive(1, 1, 4'h5, 0, 1, 0); #1;
        check("s1_valid0", b_out_valid, 1);
        check("s1_result0", b_out_result, 4'h3);
        drive(1, 1, 4'h9, 0, 1, 0); #1;
        check("s1_valid1", b_out_valid, 1);
        check("s1_result1", b_out_result, 4'h5);
        drive(1, 0, 4'h0, 0, 1, 0); #1;
        check("s1_valid2", b_out_valid, 1);
        check("s1_result2", b_out_result, 4'h9);
        check("s1_beats2", b_out_beats, 1);
        idle();

        // Random traffic on both instances.
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 60; i++) begin
                drive(k, $urandom_range(0, 3) != 0, W'($urandom_range(0, 15)),
                      $urandom_range(0, 3) == 0, $urandom_range(0, 2) != 0,
                      $urandom_range(0, 19) == 0);
            end
            idle();
            idle();
        end
        idle();
        @(negedge clock); #1;
        check("drain_a", sbq[0].size(), 0);
        check("drain_b", sbq[1].size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
